// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus types: arbiter grant/state encodings and fetch bus widths.
package cpu_bus_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundles the fetch port, data port and shared SRAM port of the arbiter.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;
    logic                  if_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_sel;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;
    logic                  mem_stall;

    logic                  ram_ce;
    logic                  ram_we;
    logic [DATA_W/8-1:0]   ram_sel;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
        output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
    );

    // Core + memory side.
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
        input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the MEM stage;
// data has priority, IF is forced through after STARVE_LIMIT back-to-back data wins.
module sram_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W       = INST_ADDR_W,
    parameter int DATA_W       = INST_DATA_W,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);
    localparam int              SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]      CNT_INIT   = 4'(LATENCY);

    arb_state_e    state_q;
    grant_e        gnt_q;
    logic [3:0]    cnt_q;
    logic [SW-1:0] starve_q, starve_d;

    logic issue, win_if, win_mem, done;

    always_comb begin
        issue   = !rst && (state_q == IDLE) && (bus.if_req || bus.mem_req);
        win_if  = bus.if_req && (!bus.mem_req || (STARVE_LIMIT != 0 && starve_q == STARVE_MAX));
        win_mem = issue && !win_if;
        done    = !rst && (state_q == BUSY) && (cnt_q == 4'd1);

        // Only data wins that actually make IF wait count toward starvation.
        starve_d = starve_q;
        if (win_if || !bus.if_req)
            starve_d = '0;
        else if (starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
    end

    // Issue-cycle SRAM drive comes straight from the winner.
    assign bus.ram_ce    = issue;
    assign bus.ram_we    = win_mem && bus.mem_we;
    assign bus.ram_sel   = !issue ? '0 : (win_if ? {(DATA_W/8){1'b1}} : bus.mem_sel);
    assign bus.ram_addr  = !issue ? {ADDR_W{1'b0}} : (win_if ? bus.if_addr : bus.mem_addr);
    assign bus.ram_wdata = win_mem ? bus.mem_wdata : '0;

    assign bus.if_ready  = done && (gnt_q == GNT_IF);
    assign bus.mem_ready = done && (gnt_q == GNT_MEM);
    assign bus.if_rdata  = bus.if_ready  ? bus.ram_rdata : '0;
    assign bus.mem_rdata = bus.mem_ready ? bus.ram_rdata : '0;
    assign bus.if_stall  = !rst && bus.if_req  && !bus.if_ready;
    assign bus.mem_stall = !rst && bus.mem_req && !bus.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= GNT_IF;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        gnt_q    <= win_if ? GNT_IF : GNT_MEM;
                        cnt_q    <= CNT_INIT;
                        starve_q <= starve_d;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: three arbiter configurations, read data checked via queues.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q_if[$];
    logic [31:0] q_mem[$];

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ic ();

    sram_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    sram_port_arbiter #(.LATENCY(3), .STARVE_LIMIT(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
    sram_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(0)) dut_c (.clk(clk), .rst(rst_c), .bus(ic));

    function automatic logic [31:0] mdata(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h3401_1100;
            32'h0000_0020: return 32'h0000_00AA;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory models: read data appears LATENCY cycles after the address.
    logic [31:0] a_rd, c_rd;
    logic [31:0] b_p0, b_p1, b_p2;
    always @(posedge clk) begin
        a_rd <= mdata(ia.ram_addr);
        c_rd <= mdata(ic.ram_addr);
        b_p0 <= mdata(ib.ram_addr);
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign ia.ram_rdata = a_rd;
    assign ib.ram_rdata = b_p2;
    assign ic.ram_rdata = c_rd;

    task automatic clear_inputs();
        ia.if_req = 0; ia.if_addr = 0; ia.mem_req = 0; ia.mem_we = 0; ia.mem_sel = 0; ia.mem_addr = 0; ia.mem_wdata = 0;
        ib.if_req = 0; ib.if_addr = 0; ib.mem_req = 0; ib.mem_we = 0; ib.mem_sel = 0; ib.mem_addr = 0; ib.mem_wdata = 0;
        ic.if_req = 0; ic.if_addr = 0; ic.mem_req = 0; ic.mem_we = 0; ic.mem_sel = 0; ic.mem_addr = 0; ic.mem_wdata = 0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_a = 1; rst_b = 1; rst_c = 1;
        clear_inputs();
        ia.if_req = 1; ia.mem_req = 1; ia.mem_addr = 32'h44; ia.mem_sel = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        got = {ia.ram_ce, ia.ram_we, ia.if_ready, ia.mem_ready, ia.if_stall, ia.mem_stall, |ia.ram_addr, |ia.ram_sel};
        n_cmp++;
        if (got !== 8'h00) begin
            n_err++; $display("FAIL reset_outputs: got %b want 00000000", got);
        end
        n_cmp++;
        if ({ia.if_rdata, ia.mem_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata: got %h want 0", {ia.if_rdata, ia.mem_rdata});
        end
        ia.if_req = 0; ia.mem_req = 0; ia.mem_addr = 0; ia.mem_sel = 0;
        @(negedge clk);
        rst_a = 0; rst_b = 0; rst_c = 0;
    endtask

    task automatic test_if_read();
        logic [31:0] got;
        @(negedge clk);
        ia.if_req = 1; ia.if_addr = 32'h4;
        q_if.push_back(32'h3401_1100);
        #1;
        n_cmp++;
        if ({ia.ram_ce, ia.ram_we, ia.if_stall, ia.if_ready} !== 4'b1010) begin
            n_err++; $display("FAIL if_issue_ctl: got %b want 1010", {ia.ram_ce, ia.ram_we, ia.if_stall, ia.if_ready});
        end
        n_cmp++;
        if (ia.ram_addr !== 32'h4) begin
            n_err++; $display("FAIL if_issue_addr: got %h want 00000004", ia.ram_addr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({ia.ram_ce, ia.if_stall, ia.if_ready} !== 3'b001) begin
            n_err++; $display("FAIL if_done_ctl: got %b want 001", {ia.ram_ce, ia.if_stall, ia.if_ready});
        end
        if (ia.if_ready && q_if.size() > 0) begin
            got = q_if.pop_front();
            n_cmp++;
            if (ia.if_rdata !== got) begin
                n_err++; $display("FAIL if_rdata: got %h want %h", ia.if_rdata, got);
            end
        end
        ia.if_req = 0;
        q_if.delete();
    endtask

    task automatic test_simultaneous();
        logic [31:0] got;
        @(negedge clk);
        ia.if_req = 1; ia.if_addr = 32'h8;
        ia.mem_req = 1; ia.mem_we = 1; ia.mem_addr = 32'h100; ia.mem_wdata = 32'hDEAD_BEEF; ia.mem_sel = 4'hF;
        q_if.push_back(mdata(32'h8));
        #1;
        n_cmp++;
        if ({ia.ram_ce, ia.ram_we, ia.ram_sel} !== 6'b11_1111 || ia.ram_addr !== 32'h100 || ia.ram_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL sim_mem_issue: got ce/we/sel %b addr %h wdata %h want 111111 00000100 deadbeef",
                              {ia.ram_ce, ia.ram_we, ia.ram_sel}, ia.ram_addr, ia.ram_wdata);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({ia.mem_ready, ia.mem_stall, ia.if_stall, ia.ram_ce} !== 4'b1010) begin
            n_err++; $display("FAIL sim_mem_done: got %b want 1010", {ia.mem_ready, ia.mem_stall, ia.if_stall, ia.ram_ce});
        end
        ia.mem_req = 0; ia.mem_we = 0;
        @(negedge clk); #1;
        n_cmp++;
        if ({ia.ram_ce, ia.ram_we, ia.if_ready} !== 3'b100 || ia.ram_addr !== 32'h8) begin
            n_err++; $display("FAIL sim_if_issue: got %b addr %h want 100 00000008", {ia.ram_ce, ia.ram_we, ia.if_ready}, ia.ram_addr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ia.if_ready !== 1'b1) begin
            n_err++; $display("FAIL sim_if_ready: got %b want 1", ia.if_ready);
        end else begin
            got = q_if.pop_front();
            n_cmp++;
            if (ia.if_rdata !== got) begin
                n_err++; $display("FAIL sim_if_rdata: got %h want %h", ia.if_rdata, got);
            end
        end
        ia.if_req = 0;
        q_if.delete();
    endtask

    task automatic test_starve();
        logic [9:0]  exp_if_seq = 10'h210;
        logic [31:0] got, want_addr;
        int k = 0;
        @(negedge clk);
        ia.if_req = 1; ia.if_addr = 32'h40;
        ia.mem_req = 1; ia.mem_we = 0; ia.mem_addr = 32'h80; ia.mem_sel = 4'hF;
        for (int c = 0; c < 60 && !(k >= 10 && q_if.size() == 0 && q_mem.size() == 0); c++) begin
            #1;
            if (ia.if_ready) begin
                n_cmp++;
                got = (q_if.size() > 0) ? q_if.pop_front() : 32'hXXXX_XXXX;
                if (ia.if_rdata !== got) begin
                    n_err++; $display("FAIL starve_if_rdata: got %h want %h", ia.if_rdata, got);
                end
            end
            if (ia.mem_ready) begin
                n_cmp++;
                got = (q_mem.size() > 0) ? q_mem.pop_front() : 32'hXXXX_XXXX;
                if (ia.mem_rdata !== got) begin
                    n_err++; $display("FAIL starve_mem_rdata: got %h want %h", ia.mem_rdata, got);
                end
            end
            if (ia.ram_ce && k < 10) begin
                want_addr = exp_if_seq[k] ? 32'h40 : 32'h80;
                n_cmp++;
                if (ia.ram_addr !== want_addr) begin
                    n_err++; $display("FAIL starve_grant_%0d: got addr %h want %h", k + 1, ia.ram_addr, want_addr);
                end
                if (exp_if_seq[k]) q_if.push_back(mdata(32'h40));
                else               q_mem.push_back(mdata(32'h80));
                k++;
            end
            if (k >= 10 && q_if.size() == 0 && q_mem.size() == 0) begin
                ia.if_req = 0; ia.mem_req = 0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (k != 10 || q_if.size() != 0 || q_mem.size() != 0) begin
            n_err++; $display("FAIL starve_timeout: got %0d issues want 10", k);
        end
        ia.if_req = 0; ia.mem_req = 0;
        q_if.delete(); q_mem.delete();
    endtask

    task automatic test_latency3();
        logic [31:0] got;
        @(negedge clk);
        ib.mem_req = 1; ib.mem_we = 0; ib.mem_addr = 32'h20; ib.mem_sel = 4'hF;
        q_mem.push_back(32'h0000_00AA);
        q_mem.push_back(32'h0000_00AA);
        #1;
        n_cmp++;
        if (ib.ram_ce !== 1'b1 || ib.ram_addr !== 32'h20) begin
            n_err++; $display("FAIL lat3_issue: got ce %b addr %h want 1 00000020", ib.ram_ce, ib.ram_addr);
        end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({ib.ram_ce, ib.mem_ready} !== {c == 4, c == 3 || c == 7}) begin
                n_err++; $display("FAIL lat3_cycle_%0d: got ce/ready %b want %b", c, {ib.ram_ce, ib.mem_ready},
                                  {c == 4, c == 3 || c == 7});
            end
            if (ib.mem_ready) begin
                got = (q_mem.size() > 0) ? q_mem.pop_front() : 32'hXXXX_XXXX;
                n_cmp++;
                if (ib.mem_rdata !== got) begin
                    n_err++; $display("FAIL lat3_rdata_%0d: got %h want %h", c, ib.mem_rdata, got);
                end
            end else if (c == 1) begin
                n_cmp++;
                if (ib.mem_rdata !== 32'h0) begin
                    n_err++; $display("FAIL lat3_rdata_idle: got %h want 0", ib.mem_rdata);
                end
            end
        end
        ib.mem_req = 0;
        q_mem.delete();
    endtask

    task automatic test_reset_midbusy();
        logic [31:0] got;
        @(negedge clk);
        ib.if_req = 1; ib.if_addr = 32'h4;
        #1;
        n_cmp++;
        if (ib.ram_ce !== 1'b1) begin
            n_err++; $display("FAIL rstbusy_issue: got ce %b want 1", ib.ram_ce);
        end
        @(negedge clk);
        rst_b = 1;
        #1;
        n_cmp++;
        if ({ib.ram_ce, ib.if_ready, ib.if_stall, ib.if_rdata} !== 35'h0) begin
            n_err++; $display("FAIL rstbusy_outputs: got %h want 0", {ib.ram_ce, ib.if_ready, ib.if_stall, ib.if_rdata});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (ib.if_ready !== 1'b0) begin
                n_err++; $display("FAIL rstbusy_no_ready_%0d: got %b want 0", c, ib.if_ready);
            end
        end
        @(negedge clk);
        rst_b = 0;
        q_if.push_back(32'h3401_1100);
        #1;
        n_cmp++;
        if (ib.ram_ce !== 1'b1 || ib.ram_addr !== 32'h4) begin
            n_err++; $display("FAIL rstbusy_reissue: got ce %b addr %h want 1 00000004", ib.ram_ce, ib.ram_addr);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({ib.ram_ce, ib.if_ready} !== {1'b0, c == 3}) begin
                n_err++; $display("FAIL rstbusy_cycle_%0d: got ce/ready %b want %b", c, {ib.ram_ce, ib.if_ready}, {1'b0, c == 3});
            end
            if (ib.if_ready) begin
                got = (q_if.size() > 0) ? q_if.pop_front() : 32'hXXXX_XXXX;
                n_cmp++;
                if (ib.if_rdata !== got) begin
                    n_err++; $display("FAIL rstbusy_rdata: got %h want %h", ib.if_rdata, got);
                end
            end
        end
        ib.if_req = 0;
        q_if.delete();
    endtask

    task automatic test_strict_priority();
        logic [31:0] got;
        int k = 0;
        int if_pulses = 0;
        @(negedge clk);
        ic.if_req = 1; ic.if_addr = 32'h40;
        ic.mem_req = 1; ic.mem_we = 0; ic.mem_addr = 32'h80; ic.mem_sel = 4'hF;
        for (int c = 0; c < 60 && !(k >= 10 && q_mem.size() == 0); c++) begin
            #1;
            if (ic.if_ready) if_pulses++;
            if (ic.mem_ready) begin
                n_cmp++;
                got = (q_mem.size() > 0) ? q_mem.pop_front() : 32'hXXXX_XXXX;
                if (ic.mem_rdata !== got) begin
                    n_err++; $display("FAIL strict_mem_rdata: got %h want %h", ic.mem_rdata, got);
                end
            end
            if (ic.ram_ce && k < 10) begin
                n_cmp++;
                if (ic.ram_addr !== 32'h80) begin
                    n_err++; $display("FAIL strict_grant_%0d: got addr %h want 00000080", k + 1, ic.ram_addr);
                end
                q_mem.push_back(mdata(32'h80));
                k++;
            end
            if (k >= 10 && q_mem.size() == 0) begin
                ic.if_req = 0; ic.mem_req = 0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (k != 10 || q_mem.size() != 0) begin
            n_err++; $display("FAIL strict_timeout: got %0d issues want 10", k);
        end
        n_cmp++;
        if (if_pulses != 0) begin
            n_err++; $display("FAIL strict_if_ready: got %0d pulses want 0", if_pulses);
        end
        ic.if_req = 0; ic.mem_req = 0;
        q_mem.delete();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_simultaneous();
        test_starve();
        test_latency3();
        test_reset_midbusy();
        test_strict_priority();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
